// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART TX engine. Host pushes are
// queued, and a two-state sequencer issues one-cycle write strobes while the
// engine reports ready, re-arming only after ready falls.
// Optional build macro: UART_FEED_CRLF_EN -- expands each 8'h0A into the pair
// 8'h0D, 8'h0A on the wire (the 0D is injected without consuming a FIFO slot).
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  input  logic              i_txrdy,
  output logic              o_write,
  output logic [7:0]        o_byte,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_busy
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ZERO_COUNT = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ZERO_PTR   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  state_t            state_r;
  state_t            state_s;
  logic              write_r;
  logic [7:0]        byte_r;
  logic              ovf_r;

  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              drop_s;
  logic              dispatch_s;
  logic              pop_s;
  logic [7:0]        head_s;
  logic [7:0]        send_byte_s;
`ifdef UART_FEED_CRLF_EN
  logic              cr_done_r;
  logic              insert_cr_s;
`endif

  // Datapath decode: full/empty from registered count, push/pop qualification.
  always_comb begin
    full_s      = (count_r == FULL_COUNT);
    empty_s     = (count_r == ZERO_COUNT);
    head_s      = mem_r[rd_ptr_r];
    // Flush overrides everything on its edge, including a same-edge push.
    push_ok_s   = i_push && !full_s && !i_flush;
    drop_s      = i_push && full_s && !i_flush;
    dispatch_s  = (state_r == IDLE) && !empty_s && i_txrdy && !i_flush;
`ifdef UART_FEED_CRLF_EN
    insert_cr_s = (head_s == 8'h0A) && !cr_done_r;
    if (insert_cr_s) begin
      send_byte_s = 8'h0D;
      pop_s       = 1'b0;
    end else begin
      send_byte_s = head_s;
      pop_s       = dispatch_s;
    end
`else
    send_byte_s = head_s;
    pop_s       = dispatch_s;
`endif
  end

  // Next-state logic: WAIT_LOW blocks re-dispatch until ready has dropped.
  always_comb begin
    state_s = state_r;
    if (i_flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (dispatch_s) begin
            state_s = WAIT_LOW;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_LOW: begin
          if (!i_txrdy) begin
            state_s = IDLE;
          end else begin
            state_s = WAIT_LOW;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers and occupancy count; simultaneous push and pop leave count alone.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_COUNT;
    end else if (i_flush) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_COUNT;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + ONE_COUNT;
        2'b01:   count_r <= count_r - ONE_COUNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write strobe and byte; the byte holds between strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      write_r <= 1'b0;
      byte_r  <= 8'h00;
    end else if (i_flush) begin
      write_r <= 1'b0;
    end else begin
      write_r <= dispatch_s;
      if (dispatch_s) begin
        byte_r <= send_byte_s;
      end
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (i_clr_ovf) begin
      ovf_r <= 1'b0;
    end
  end

`ifdef UART_FEED_CRLF_EN
  // Remembers that the CR for the current head LF has already gone out.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cr_done_r <= 1'b0;
    end else if (i_flush) begin
      cr_done_r <= 1'b0;
    end else if (dispatch_s) begin
      cr_done_r <= insert_cr_s;
    end
  end
`endif

  assign o_write    = write_r;
  assign o_byte     = byte_r;
  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_count    = count_r;
  assign o_overflow = ovf_r;
  assign o_busy     = (state_r != IDLE) || !empty_s;

endmodule
